// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: runs a small program memory through FETCH/DECODE/ISSUE and hands each word to the ALU stage.
// Latency: the first ir_valid appears 3 cycles after start; the best case is one instruction every 3 cycles.
// Backpressure: ir and pc are held while ir_valid=1 and ir_ready=0; sequencing stops on HALT_OP or after the last word.
//
// Ports:
//   clk, sys_rst_n                 clock, synchronous active-low reset
//   load_en/load_addr/load_data    program-memory write port (accepted only in IDLE or HALT)
//   start                          begin at pc 0 (ignored while busy)
//   ir/ir_valid/ir_ready           instruction handshake to the downstream ALU stage
//   pc                             address of the current instruction
//   busy/halted                    status (busy = FETCH/DECODE/ISSUE, halted = HALT)
module inst_fetch_seq #(
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    output logic [31:0]   ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_ir;
    logic          r_ir_valid;
    logic [AW-1:0] r_pc;
    logic          r_busy;
    logic          r_halted;

    logic          w_load_ok;
    logic          w_xfer;
    logic          w_last;

    // Writes are blocked while the program runs and during reset; the array
    // itself has no reset so a program survives sys_rst_n.
    assign w_load_ok = load_en && sys_rst_n && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_xfer    = r_ir_valid && ir_ready;
    assign w_last    = (r_pc == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    // A load in this same cycle has already committed when FETCH reads.
                    if (start) begin
                        r_pc     <= '0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (r_ir[31:27] == HALT_OP) begin
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_ir_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_xfer) begin
                        r_ir_valid <= 1'b0;
                        // The last word ends the run with pc parked on it, no wrap.
                        if (w_last) begin
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_ir_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_halted   <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc       = r_pc;
    assign busy     = r_busy;
    assign halted   = r_halted;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: program load, handshake stalls, halt/no-wrap, reset and load gating.
// Inputs are driven and outputs sampled on the falling edge.
// Transfers are recorded when ir_valid and ir_ready are both seen high at a falling edge.
module tb_inst_fetch_seq;

    localparam logic [31:0] W0   = 32'h0840_0005;
    localparam logic [31:0] W1   = 32'h1000_0000;
    localparam logic [31:0] WH   = 32'hF800_0000;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_ir [20];
    logic [3:0]  got_pc [20];
    int          got_t  [20];

    always #5 clk = ~clk;

    inst_fetch_seq #(.DEPTH(16), .AW(4), .HALT_OP(5'b11111)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    // Stimulus helpers (no checking inside); all are entered at a falling edge.
    task automatic load_word(input logic [3:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (ir_valid === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Runs until halted or the cycle limit, recording every transfer;
    // start is raised while exactly start_at transfers have been seen.
    task automatic run_collect(input int limit, input int start_at, output int n);
        n = 0;
        for (int cyc = 0; cyc < limit && halted !== 1'b1; cyc++) begin
            start = (n == start_at);
            if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
                if (n < 20) begin
                    got_ir[n] = ir;
                    got_pc[n] = pc;
                    got_t[n]  = cyc;
                end
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 32'hFFFF_FFFF;
        ir_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=00000000", ir); end
        checks++; if (pc !== 4'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        sys_rst_n = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_idle_stays got busy=%b halted=%b exp 0/0", busy, halted); end
    endtask

    task automatic test_basic();
        int cycles;
        int n;
        load_word(4'd0, W0);
        load_word(4'd1, W1);
        load_word(4'd2, WH);
        ir_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (ir_valid !== 1'b1 && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        checks++; if (cycles != 3) begin failures++; $display("FAIL basic_first_valid_cycle got=%0d exp=3", cycles); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        run_collect(40, -1, n);
        checks++; if (n != 2) begin failures++; $display("FAIL basic_xfer_count got=%0d exp=2", n); end
        checks++; if (got_ir[0] !== W0 || got_pc[0] !== 4'd0) begin failures++; $display("FAIL basic_xfer0 got ir=%h pc=%0d exp ir=%h pc=0", got_ir[0], got_pc[0], W0); end
        checks++; if (got_ir[1] !== W1 || got_pc[1] !== 4'd1) begin failures++; $display("FAIL basic_xfer1 got ir=%h pc=%0d exp ir=%h pc=1", got_ir[1], got_pc[1], W1); end
        checks++; if (got_t[1] - got_t[0] != 3) begin failures++; $display("FAIL basic_interval got=%0d exp=3", got_t[1] - got_t[0]); end
        checks++; if (halted !== 1'b1 || pc !== 4'd2 || busy !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL basic_halt got halted=%b pc=%0d busy=%b vld=%b exp 1/2/0/0", halted, pc, busy, ir_valid); end
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        ir_ready = 1'b0;
        pulse_start();
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_valid_timeout got=0 exp=1"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ir_valid !== 1'b1 || ir !== W0 || pc !== 4'd0) begin
                failures++;
                $display("FAIL stall_hold_%0d got vld=%b ir=%h pc=%0d exp 1/%h/0", i, ir_valid, ir, pc, W0);
            end
            @(negedge clk);
        end
        ir_ready = 1'b1;
        run_collect(40, -1, n);
        checks++; if (n != 2 || got_pc[0] !== 4'd0 || got_ir[0] !== W0 || got_pc[1] !== 4'd1) begin failures++; $display("FAIL stall_xfers got n=%0d pc0=%0d ir0=%h pc1=%0d exp 2/0/%h/1", n, got_pc[0], got_ir[0], got_pc[1], W0); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL stall_halt got=%b exp=1", halted); end
    endtask

    task automatic test_load_during_issue();
        bit ok;
        int n;
        ir_ready = 1'b0;
        pulse_start();
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ldissue_valid_timeout got=0 exp=1"); end
        load_word(4'd0, WH);
        ir_ready = 1'b1;
        run_collect(40, -1, n);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL ldissue_halt got=%b exp=1", halted); end
        pulse_start();
        wait_valid(10, ok);
        checks++; if (!ok || ir !== W0 || pc !== 4'd0) begin failures++; $display("FAIL ldissue_restart got ok=%b ir=%h pc=%0d exp 1/%h/0", ok, ir, pc, W0); end
        run_collect(40, -1, n);
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        int n;
        ir_ready = 1'b0;
        pulse_start();
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstissue_valid_timeout got=0 exp=1"); end
        sys_rst_n = 1'b0;
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = WH;
        @(negedge clk);
        sys_rst_n = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || pc !== 4'd0) begin failures++; $display("FAIL rstissue_regs got vld=%b ir=%h pc=%0d exp 0/00000000/0", ir_valid, ir, pc); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL rstissue_status got busy=%b halted=%b exp 0/0", busy, halted); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL rstissue_idle got busy=%b vld=%b exp 0/0", busy, ir_valid); end
        ir_ready = 1'b1;
        pulse_start();
        wait_valid(10, ok);
        checks++; if (!ok || ir !== W0 || pc !== 4'd0) begin failures++; $display("FAIL rstissue_rerun got ok=%b ir=%h pc=%0d exp 1/%h/0", ok, ir, pc, W0); end
        run_collect(40, -1, n);
        checks++; if (n != 2 || halted !== 1'b1) begin failures++; $display("FAIL rstissue_rerun_xfers got n=%0d halted=%b exp 2/1", n, halted); end
    endtask

    task automatic test_load_start_same();
        bit ok;
        int n;
        ir_ready  = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 32'h0;
        start     = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        start   = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || ir !== 32'h0 || pc !== 4'd0) begin failures++; $display("FAIL ldstart_first got ok=%b ir=%h pc=%0d exp 1/00000000/0", ok, ir, pc); end
        run_collect(40, -1, n);
        checks++; if (n != 2 || got_ir[1] !== W1 || halted !== 1'b1) begin failures++; $display("FAIL ldstart_run got n=%0d ir1=%h halted=%b exp 2/%h/1", n, got_ir[1], halted, W1); end
    endtask

    task automatic test_full_no_wrap();
        logic [31:0] w;
        int n;
        for (int i = 0; i < 16; i++) begin
            w = {5'b00001, 27'(i * 3 + 1)};
            load_word(4'(i), w);
        end
        ir_ready = 1'b1;
        pulse_start();
        // start is raised again mid-run and must be ignored while busy.
        run_collect(100, 5, n);
        checks++; if (n != 16) begin failures++; $display("FAIL full_xfer_count got=%0d exp=16", n); end
        for (int i = 0; i < 16; i++) begin
            w = {5'b00001, 27'(i * 3 + 1)};
            checks++;
            if (got_ir[i] !== w || got_pc[i] !== 4'(i)) begin
                failures++;
                $display("FAIL full_xfer_%0d got ir=%h pc=%0d exp ir=%h pc=%0d", i, got_ir[i], got_pc[i], w, i);
            end
        end
        checks++; if (got_t[15] - got_t[0] != 45) begin failures++; $display("FAIL full_interval got=%0d exp=45", got_t[15] - got_t[0]); end
        repeat (3) @(negedge clk);
        checks++; if (halted !== 1'b1 || pc !== 4'd15 || ir_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_no_wrap got halted=%b pc=%0d vld=%b busy=%b exp 1/15/0/0", halted, pc, ir_valid, busy); end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        load_en   = 1'b0;
        load_addr = 4'd0;
        load_data = 32'h0;
        start     = 1'b0;
        ir_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_load_during_issue();
        test_reset_mid_issue();
        test_load_start_same();
        test_full_no_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch_seq.md
INST_FETCH_SEQ -- requirements
Module: inst_fetch_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, program memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 4, PC and load-address width; DEPTH = 2**AW.
REQ-003 SHALL have parameter HALT_OP, default 5'b11111, the oper_type (IR[31:27]) code that stops sequencing.
REQ-004 SHALL have one clock, clk; reset is synchronous and active-low, port sys_rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 sys_rst_n  input  1  synchronous active-low reset.
REQ-007 load_en  input  1  program-memory write strobe.
REQ-008 load_addr  input  AW  program-memory write address.
REQ-009 load_data  input  32  program-memory write data.
REQ-010 start  input  1  begin execution at PC 0.
REQ-011 ir  output  32  instruction register presented to the downstream ALU stage.
REQ-012 ir_valid  output  1  ir holds an instruction awaiting acceptance.
REQ-013 ir_ready  input  1  ALU stage accepts ir this cycle.
REQ-014 pc  output  AW  address of the current instruction.
REQ-015 busy  output  1  high in FETCH, DECODE, ISSUE.
REQ-016 halted  output  1  high in HALT.

Function
REQ-017 SHALL implement an FSM with states IDLE, FETCH, DECODE, ISSUE, HALT.
REQ-018 IDLE: start=1 -> pc<=0, go to FETCH; otherwise stay.
REQ-019 FETCH, one cycle: ir <= mem[pc]; go to DECODE.
REQ-020 DECODE, one cycle: ir[31:27]==HALT_OP -> HALT, ir not issued; otherwise -> ISSUE.
REQ-021 ISSUE: ir_valid=1; transfer occurs on a cycle with ir_valid=1 and ir_ready=1.
REQ-022 On transfer with pc==DEPTH-1 -> HALT; pc holds, no wrap.
REQ-023 On transfer with pc<DEPTH-1 -> pc<=pc+1, go to FETCH.
REQ-024 ir and pc SHALL stay stable while ir_valid=1 and ir_ready=0, for any number of cycles.
REQ-025 ir_valid SHALL be registered and low in every state except ISSUE; ir_valid drops the cycle after the transfer.
REQ-026 Minimum issue interval SHALL be 3 cycles per instruction (FETCH, DECODE, ISSUE with ir_ready already high).
REQ-027 HALT: halted=1; start=1 -> pc<=0, halted<=0, go to FETCH; otherwise stay.
REQ-028 load_en SHALL write mem[load_addr]<=load_data only in IDLE or HALT; ignored in FETCH, DECODE, ISSUE.
REQ-029 load_en and start in the same IDLE/HALT cycle: write commits at that edge; the following FETCH SHALL see the new data.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 ir_ready while ir_valid=0 SHALL have no effect.
REQ-032 Memory SHALL be a synchronous-write, registered-read array; pc indexes it directly.

Reset
REQ-033 sys_rst_n=0 at a clock edge: state<=IDLE, pc<=0, ir<=0, ir_valid<=0, busy<=0, halted<=0.
REQ-034 Reset SHALL override all other inputs, including start and load_en asserted in the same cycle.
REQ-035 Reset mid-ISSUE SHALL drop ir_valid the next cycle, with no transfer counted.
REQ-036 Program-memory contents SHALL NOT be cleared by reset.

Verification
REQ-037 Load mem[0]=0x0840_0005, mem[1]=0x1000_0000, mem[2]=0xF800_0000, pulse start, ir_ready=1 -> first ir_valid is the 3rd cycle after start; issues 0x08400005 at pc=0, then 0x10000000 at pc=1; halted=1, pc=2, and mem[2] is never issued.
REQ-038 Same program, ir_ready=0 for 5 cycles during the first issue -> ir=0x08400005 and pc=0 held for all 5 cycles; exactly one transfer.
REQ-039 All 16 words non-halt -> 16 transfers, pc stops at 15, halted=1, no wrap to 0.
REQ-040 load_en pulsed to addr 0 during ISSUE -> mem unchanged; a restart from HALT issues the original word.
REQ-041 sys_rst_n=0 for one cycle mid-ISSUE -> next cycle ir_valid=0, ir=0, pc=0, state IDLE; start then re-runs the program from pc=0.
REQ-042 In HALT, load_en (addr 0, 0x0000_0000) and start in the same cycle -> first issued ir=0x00000000 at pc=0.
